fuzz_response_capture: RTL and testbench

//  Consumer end of the fuzz DUT's output bus: samples the DUT's wide y output every clock for a

---
 rtl/fuzz_pkg.sv | 23 ++
 rtl/fuzz_misr.sv | 33 +++
 rtl/fuzz_response_capture.sv | 128 ++++++++++++
 tb/tb_fuzz_response_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fuzz_pkg.sv
// Shared types and constants for the fuzz response capture block.
// FUZZ_CYCLE_COUNT_EN appends a 4-byte cycle count to each signature frame.
package fuzz_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam logic [191:0] MISR_POLY_DEFAULT = 192'h87;

`ifdef FUZZ_CYCLE_COUNT_EN
  localparam int CYC_BYTES = 4;
`else
  localparam int CYC_BYTES = 0;
`endif

  function automatic int frame_bytes(input int y_width);
    return y_width / 8 + CYC_BYTES;
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// Multiple-input signature register: shift left, fold the MSB back through POLY, xor in d.
module fuzz_misr
  import fuzz_pkg::*;
#(
  parameter int               WIDTH = 192,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_fold;

  assign w_fold = r_sig[WIDTH-1] ? POLY : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (clear) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= {r_sig[WIDTH-2:0], 1'b0} ^ w_fold ^ d;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/fuzz_response_capture.sv
// Folds NUM_CYCLES samples of y_in into a MISR, then streams the signature LSB-first as bytes.
// FUZZ_CYCLE_COUNT_EN adds a free-running cycle counter, latched at end of capture and sent last.
module fuzz_response_capture
  import fuzz_pkg::*;
#(
  parameter int                 Y_WIDTH    = 192,
  parameter int                 NUM_CYCLES = 256,
  parameter logic [Y_WIDTH-1:0] MISR_POLY  = Y_WIDTH'(MISR_POLY_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [Y_WIDTH-1:0] y_in,
  output logic               busy,
  output logic               done,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready
);

  localparam int CNT_W = $clog2(NUM_CYCLES + 1);
  localparam int IDX_W = $clog2(Y_WIDTH / 8 + 4);
  localparam int FRAME = frame_bytes(Y_WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_done;
  logic [Y_WIDTH-1:0] w_sig;
  logic [FRAME*8-1:0] w_frame;
  logic [7:0]         w_byte;
  logic               w_start_ok;
  logic               w_last_sample;
  logic               w_accept;
  logic               w_last_byte;

  // A start landing in the done cycle is dropped so a frame never restarts on its own tail.
  assign w_start_ok    = (r_state == IDLE) && start && !r_done;
  assign w_last_sample = (r_state == CAPTURE) && (r_cnt == CNT_W'(NUM_CYCLES - 1));
  assign w_accept      = (r_state == SEND) && tx_ready;
  assign w_last_byte   = w_accept && (r_idx == IDX_W'(FRAME - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok)    w_next = CAPTURE;
      CAPTURE: if (w_last_sample) w_next = SEND;
      SEND:    if (w_last_byte)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_byte;
      if (w_start_ok) begin
        r_cnt <= '0;
      end else if ((r_state == CAPTURE) && (r_cnt != CNT_W'(NUM_CYCLES))) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_start_ok) begin
        r_idx <= '0;
      end else if (w_accept && !w_last_byte) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  fuzz_misr #(
    .WIDTH (Y_WIDTH),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (w_start_ok),
    .en    (r_state == CAPTURE),
    .d     (y_in),
    .sig   (w_sig)
  );

`ifdef FUZZ_CYCLE_COUNT_EN
  logic [31:0] r_cyc;
  logic [31:0] r_cyc_lat;

  // Latched value is the count seen in the first SEND cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc     <= '0;
      r_cyc_lat <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (w_last_sample) begin
        r_cyc_lat <= r_cyc + 32'd1;
      end
    end
  end

  assign w_frame = {r_cyc_lat, w_sig};
`else
  assign w_frame = w_sig;
`endif

  always_comb begin
    w_byte = '0;
    for (int k = 0; k < FRAME; k++) begin
      if (r_idx == IDX_W'(k)) w_byte = w_frame[8*k +: 8];
    end
  end

  assign tx_valid = (r_state == SEND);
  assign tx_data  = tx_valid ? w_byte : 8'h00;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_fuzz_response_capture.sv
// Directed bench for fuzz_response_capture: NUM_CYCLES=4 main instance plus a NUM_CYCLES=1 instance.
module tb_fuzz_response_capture;

`ifdef FUZZ_CYCLE_COUNT_EN
  localparam int FRAME = 28;
`else
  localparam int FRAME = 24;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [191:0] y_in = '0;
  logic         busy, done, tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready = 1'b1;

  logic         start1 = 1'b0;
  logic [191:0] y1 = '0;
  logic         busy1, done1, valid1;
  logic [7:0]   data1;
  logic         ready1 = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] rx [0:31];
  int rx_n, done_n, stall_bad;

  always #5 clk = ~clk;

  fuzz_response_capture #(.NUM_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in), .busy(busy), .done(done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  fuzz_response_capture #(.NUM_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_in(y1), .busy(busy1), .done(done1),
    .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1)
  );

  function automatic logic [191:0] rx_sig();
    logic [191:0] s;
    for (int k = 0; k < 24; k++) s[8*k +: 8] = rx[k];
    return s;
  endfunction

  // Start pulse then four samples; returns at the negedge of the first SEND cycle.
  task automatic do_capture(input logic [191:0] a, input logic [191:0] b,
                            input logic [191:0] c, input logic [191:0] d);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; y_in = a;
    @(negedge clk); y_in = b;
    @(negedge clk); y_in = c;
    @(negedge clk); y_in = d;
    @(negedge clk); y_in = '0;
  endtask

  // Gathers accepted bytes until done; stall selects the 1,0,0,1 ready pattern.
  task automatic collect(input bit stall, input bit poke);
    int cyc;
    logic [7:0] prev;
    bit was_stalled;
    cyc = 0; prev = '0; was_stalled = 0;
    rx_n = 0; done_n = 0; stall_bad = 0;
    while (done_n == 0 && cyc < 400) begin
      tx_ready = stall ? (((cyc % 4) == 0) || ((cyc % 4) == 3)) : 1'b1;
      start = poke && (cyc == 2);
      if (was_stalled && tx_valid && (tx_data !== prev)) stall_bad++;
      if (tx_valid && tx_ready && rx_n < 32) begin
        rx[rx_n] = tx_data;
        rx_n++;
      end
      if (done) done_n++;
      was_stalled = tx_valid && !tx_ready;
      prev = tx_data;
      if (done_n == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", tx_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", tx_data); else n_pass++;
    n_total++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 got=%b exp=0", busy1); else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_zero();
    do_capture('0, '0, '0, '0);
    n_total++; if (busy !== 1'b1) $display("FAIL zero_busy_send got=%b exp=1", busy); else n_pass++;
    collect(1'b0, 1'b0);
    n_total++; if (rx_n != FRAME) $display("FAIL zero_len got=%0d exp=%0d", rx_n, FRAME); else n_pass++;
    n_total++; if (rx_sig() !== '0) $display("FAIL zero_sig got=%h exp=0", rx_sig()); else n_pass++;
    n_total++; if (done_n != 1) $display("FAIL zero_done got=%0d exp=1", done_n); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL zero_busy_done got=%b exp=0", busy); else n_pass++;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_total++; if (done !== 1'b0) $display("FAIL zero_done_once got=%b exp=0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL zero_start_on_done got=%b exp=0", busy); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL zero_valid_idle got=%b exp=0", tx_valid); else n_pass++;
  endtask

  task automatic test_misr();
    logic [191:0] ys [0:4][0:3];
    logic [191:0] exp_sig [0:4];
    logic [191:0] msb;
    msb = 192'd1 << 191;
    ys[0] = '{192'd1, 192'd0, 192'd0, 192'd0};          exp_sig[0] = 192'h8;
    ys[1] = '{msb, 192'd0, 192'd0, 192'd0};             exp_sig[1] = 192'h21C;
    ys[2] = '{192'd0, 192'd0, msb, 192'd0};             exp_sig[2] = 192'h87;
    ys[3] = '{192'hFF, 192'h1, 192'd0, 192'hA5};        exp_sig[3] = 192'h759;
    ys[4] = '{msb, msb, 192'd0, 192'd0};                exp_sig[4] = 192'h312;
    for (int v = 0; v < 5; v++) begin
      do_capture(ys[v][0], ys[v][1], ys[v][2], ys[v][3]);
      collect(1'b0, 1'b0);
      n_total++; if (rx_sig() !== exp_sig[v]) $display("FAIL misr_sig[%0d] got=%h exp=%h", v, rx_sig(), exp_sig[v]); else n_pass++;
      n_total++; if (rx_n != FRAME) $display("FAIL misr_len[%0d] got=%0d exp=%0d", v, rx_n, FRAME); else n_pass++;
      n_total++; if (done_n != 1) $display("FAIL misr_done[%0d] got=%0d exp=1", v, done_n); else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [191:0] p;
    for (int k = 0; k < 24; k++) p[8*k +: 8] = 8'(k + 1);
    do_capture('0, '0, '0, p);
    collect(1'b1, 1'b1);
    n_total++; if (rx_n != FRAME) $display("FAIL stall_len got=%0d exp=%0d", rx_n, FRAME); else n_pass++;
    n_total++; if (rx_sig() !== p) $display("FAIL stall_sig got=%h exp=%h", rx_sig(), p); else n_pass++;
    n_total++; if (stall_bad != 0) $display("FAIL stall_stable got=%0d changes exp=0", stall_bad); else n_pass++;
    n_total++; if (done_n != 1) $display("FAIL stall_done got=%0d exp=1", done_n); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL stall_start_ignored got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [191:0] p;
    int n, cyc;
    for (int k = 0; k < 24; k++) p[8*k +: 8] = 8'(k + 1);
    do_capture('0, '0, '0, p);
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      if (tx_valid) n++;
      @(negedge clk);
      cyc++;
    end
    n_total++; if (tx_data !== 8'd11) $display("FAIL rstmid_byte10 got=%h exp=0b", tx_data); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", tx_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL rstmid_data got=%h exp=00", tx_data); else n_pass++;
    @(negedge clk); rst = 1'b0;
    do_capture(192'hFF, 192'h1, 192'd0, 192'hA5);
    collect(1'b0, 1'b0);
    n_total++; if (rx_n != FRAME) $display("FAIL rstmid_len got=%0d exp=%0d", rx_n, FRAME); else n_pass++;
    n_total++; if (rx_sig() !== 192'h759) $display("FAIL rstmid_sig got=%h exp=759", rx_sig()); else n_pass++;
    n_total++; if (done_n != 1) $display("FAIL rstmid_done got=%0d exp=1", done_n); else n_pass++;
  endtask

  task automatic test_single_sample();
    logic [191:0] vin [0:1];
    int cyc;
    bit seen;
    vin[0] = 192'd1;
    vin[1] = 192'd1 << 191;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0; y1 = vin[v];
      @(negedge clk); y1 = '0;
      rx_n = 0; cyc = 0; seen = 0;
      while (!seen && cyc < 100) begin
        if (valid1 && rx_n < 32) begin
          rx[rx_n] = data1;
          rx_n++;
        end
        if (done1) seen = 1;
        else begin
          @(negedge clk);
          cyc++;
        end
      end
      n_total++; if (rx_sig() !== vin[v]) $display("FAIL single_sig[%0d] got=%h exp=%h", v, rx_sig(), vin[v]); else n_pass++;
      n_total++; if (rx_n != FRAME) $display("FAIL single_len[%0d] got=%0d exp=%0d", v, rx_n, FRAME); else n_pass++;
      n_total++; if (!seen) $display("FAIL single_done[%0d] got=0 exp=1", v); else n_pass++;
    end
  endtask

`ifdef FUZZ_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (99) @(negedge clk);
    do_capture('0, '0, '0, '0);
    collect(1'b0, 1'b0);
    n_total++; if (rx_n != 28) $display("FAIL cyc_len got=%0d exp=28", rx_n); else n_pass++;
    n_total++; if ({rx[27], rx[26], rx[25], rx[24]} !== 32'd105)
      $display("FAIL cyc_count got=%0d exp=105", {rx[27], rx[26], rx[25], rx[24]}); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_misr();
    test_stall();
    test_reset_mid();
    test_single_sample();
`ifdef FUZZ_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
